// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU and a word-wide data memory.
// Sub-word stores use read-modify-write; misaligned or illegal accesses fail fast.
module dmem_lsu #(
   parameter int MEM_AW = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_ena,
   output logic              mem_rena,
   output logic              mem_wena,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

   state_t            state;
   logic              we_q;
   logic [1:0]        size_q;
   logic              sx_q;
   logic [MEM_AW+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       cap_q;

   logic        bad;
   logic        word_st;
   logic        sub_st;
   logic        in_acc;
   logic        in_wr;
   logic [4:0]  lane;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_val;
   logic [31:0] merged;
   logic        unused_addr;

   assign unused_addr = ^addr[31:MEM_AW+2];

   always_comb begin
      bad = 1'b0;
      unique case (1'b1)
         (size == 2'b11): bad = 1'b1;
         (size == 2'b01): bad = addr[0];
         (size == 2'b10): bad = |addr[1:0];
         default:         bad = 1'b0;
      endcase
   end

   assign word_st = we_q && (size_q == 2'b10);
   assign sub_st  = we_q && (size_q != 2'b10);
   assign in_acc  = (state == ACCESS);
   assign in_wr   = (state == WRITE);
   assign lane    = {addr_q[1:0], 3'b000};

   always_comb begin
      ld_b   = mem_rdata[lane +: 8];
      ld_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_val = mem_rdata;
      unique case (size_q)
         2'b00:   ld_val = {{24{sx_q & ld_b[7]}}, ld_b};
         2'b01:   ld_val = {{16{sx_q & ld_h[15]}}, ld_h};
         default: ld_val = mem_rdata;
      endcase
   end

   // Replace only the addressed lane(s) of the word captured during ACCESS.
   always_comb begin
      merged = cap_q;
      if (size_q == 2'b00)
         merged[lane +: 8] = wdata_q[7:0];
      else if (addr_q[1])
         merged[31:16] = wdata_q[15:0];
      else
         merged[15:0] = wdata_q[15:0];
   end

   assign busy     = (state != IDLE);
   assign mem_ena  = in_acc | in_wr;
   assign mem_rena = in_acc & ~word_st;
   assign mem_wena = (in_acc & word_st) | in_wr;
   assign mem_addr = mem_ena ? addr_q[MEM_AW+1:2] : '0;

   always_comb begin
      mem_wdata = '0;
      if (in_wr)
         mem_wdata = merged;
      else if (in_acc && word_st)
         mem_wdata = wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sx_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cap_q   <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  we_q    <= we;
                  size_q  <= size;
                  sx_q    <= sign_ext;
                  addr_q  <= addr[MEM_AW+1:0];
                  wdata_q <= wdata;
                  if (bad) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!we_q)
                  rdata <= ld_val;
               if (sub_st) begin
                  cap_q <= mem_rdata;
                  state <= WRITE;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            WRITE: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory.
// Each scenario task checks its own results against hand-computed values.
module tb_dmem_lsu;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [1:0]    size = 2'b00;
   logic          sign_ext = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic          busy, done, err;
   logic [31:0]   rdata;
   logic          mem_ena, mem_rena, mem_wena;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0] mem [0:(1<<AW)-1];

   int n_vec = 0;
   int n_fail = 0;
   int ena_cnt = 0;
   int done_cnt = 0;
   logic [AW-1:0] last_addr = '0;
   logic [31:0]   last_wdata = '0;

   dmem_lsu #(.MEM_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
      .done(done), .err(err), .rdata(rdata), .mem_ena(mem_ena),
      .mem_rena(mem_rena), .mem_wena(mem_wena), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_ena ? mem[mem_addr] : 32'h0;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (mem_ena) begin
         ena_cnt   <= ena_cnt + 1;
         last_addr <= mem_addr;
      end
      if (mem_ena && mem_wena) begin
         mem[mem_addr] <= mem_wdata;
         last_wdata    <= mem_wdata;
      end
   end

   task automatic do_access(input logic w, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a,
                            input logic [31:0] d,
                            output int lat, output logic e);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 99;
      e = 1'bx;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            e = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_vec++; if ({busy, done, err} !== 3'b000) begin n_fail++;
         $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
      n_vec++; if (rdata !== 32'h0) begin n_fail++;
         $display("FAIL reset_rdata: got %h want 0", rdata); end
      n_vec++; if ({mem_ena, mem_rena, mem_wena} !== 3'b000 ||
                   mem_addr !== '0 || mem_wdata !== 32'h0) begin n_fail++;
         $display("FAIL reset_mem: got ena=%b addr=%h wd=%h want 0",
                  {mem_ena, mem_rena, mem_wena}, mem_addr, mem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word();
      int lat; logic e;
      do_access(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, lat, e);
      n_vec++; if (lat !== 2 || e !== 1'b0) begin n_fail++;
         $display("FAIL sw_lat: got %0d err=%b want 2 err=0", lat, e); end
      n_vec++; if (last_addr !== 11'd4 || mem[4] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL sw_mem: got addr=%0d mem=%h want 4 deadbeef",
                  last_addr, mem[4]); end
      do_access(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, e);
      n_vec++; if (lat !== 2 || e !== 1'b0 || rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL lw: got lat=%0d err=%b rd=%h want 2 0 deadbeef",
                  lat, e, rdata); end
      n_vec++; if (last_addr !== 11'd4) begin n_fail++;
         $display("FAIL lw_addr: got %0d want 4", last_addr); end
   endtask

   task automatic test_byte();
      int lat; logic e;
      do_access(1'b1, 2'b10, 1'b0, 32'h020, 32'h11223344, lat, e);
      do_access(1'b1, 2'b00, 1'b0, 32'h022, 32'h000000AA, lat, e);
      n_vec++; if (lat !== 3 || e !== 1'b0) begin n_fail++;
         $display("FAIL sb_lat: got %0d err=%b want 3 err=0", lat, e); end
      n_vec++; if (last_wdata !== 32'h11AA3344 || mem[8] !== 32'h11AA3344)
      begin n_fail++;
         $display("FAIL sb_merge: got wd=%h mem=%h want 11aa3344",
                  last_wdata, mem[8]); end
      do_access(1'b0, 2'b00, 1'b1, 32'h022, 32'h0, lat, e);
      n_vec++; if (lat !== 2 || rdata !== 32'hFFFFFFAA) begin n_fail++;
         $display("FAIL lb: got lat=%0d rd=%h want 2 ffffffaa", lat, rdata); end
      do_access(1'b0, 2'b00, 1'b0, 32'h022, 32'h0, lat, e);
      n_vec++; if (rdata !== 32'h000000AA) begin n_fail++;
         $display("FAIL lbu: got %h want 000000aa", rdata); end
      do_access(1'b0, 2'b00, 1'b1, 32'h023, 32'h0, lat, e);
      n_vec++; if (rdata !== 32'h00000011) begin n_fail++;
         $display("FAIL lb_lane3: got %h want 00000011", rdata); end
   endtask

   task automatic test_half();
      int lat; logic e;
      do_access(1'b1, 2'b10, 1'b0, 32'h024, 32'h11AA3344, lat, e);
      do_access(1'b1, 2'b01, 1'b0, 32'h026, 32'h00008001, lat, e);
      n_vec++; if (lat !== 3 || mem[9] !== 32'h80013344) begin n_fail++;
         $display("FAIL sh: got lat=%0d mem=%h want 3 80013344",
                  lat, mem[9]); end
      do_access(1'b0, 2'b01, 1'b1, 32'h026, 32'h0, lat, e);
      n_vec++; if (rdata !== 32'hFFFF8001) begin n_fail++;
         $display("FAIL lh: got %h want ffff8001", rdata); end
      do_access(1'b0, 2'b01, 1'b0, 32'h026, 32'h0, lat, e);
      n_vec++; if (rdata !== 32'h00008001) begin n_fail++;
         $display("FAIL lhu: got %h want 00008001", rdata); end
      do_access(1'b0, 2'b01, 1'b1, 32'h024, 32'h0, lat, e);
      n_vec++; if (rdata !== 32'h00003344) begin n_fail++;
         $display("FAIL lh_low: got %h want 00003344", rdata); end
   endtask

   task automatic test_misalign();
      int lat; logic e;
      int ena0;
      logic [31:0] rd0;
      logic [31:0] av [3] = '{32'h013, 32'h015, 32'h010};
      logic [1:0]  sv [3] = '{2'b10, 2'b01, 2'b11};
      rd0  = rdata;
      ena0 = ena_cnt;
      for (int k = 0; k < 3; k++) begin
         do_access(1'b0, sv[k], 1'b0, av[k], 32'h0, lat, e);
         n_vec++; if (lat !== 1 || e !== 1'b1 || rdata !== rd0) begin
            n_fail++;
            $display("FAIL misalign_%0d: got lat=%0d err=%b rd=%h want 1 1 %h",
                     k, lat, e, rdata, rd0); end
      end
      do_access(1'b1, 2'b10, 1'b0, 32'h012, 32'h12345678, lat, e);
      n_vec++; if (lat !== 1 || e !== 1'b1) begin n_fail++;
         $display("FAIL misalign_sw: got lat=%0d err=%b want 1 1", lat, e); end
      n_vec++; if (ena_cnt !== ena0) begin n_fail++;
         $display("FAIL misalign_ena: got %0d enables want 0",
                  ena_cnt - ena0); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h021; wdata = 32'h55;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #2;
      n_vec++; if (mem_wena !== 1'b1 || busy !== 1'b1) begin n_fail++;
         $display("FAIL write_state: got wena=%b busy=%b want 1 1",
                  mem_wena, busy); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (mem_wena !== 1'b0 || mem_ena !== 1'b0 || busy !== 1'b0)
      begin n_fail++;
         $display("FAIL async_reset: got wena=%b ena=%b busy=%b want 0 0 0",
                  mem_wena, mem_ena, busy); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++; if (mem[8] !== 32'h11AA3344) begin n_fail++;
         $display("FAIL reset_lost_store: got %h want 11aa3344", mem[8]); end
   endtask

   task automatic test_busy();
      int d0, e0;
      @(negedge clk);
      d0 = done_cnt; e0 = ena_cnt;
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h010;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      req = 1'b1; addr = 32'h020;
      @(negedge clk);
      req = 1'b0;
      repeat (6) @(negedge clk);
      n_vec++; if (done_cnt - d0 !== 1 || ena_cnt - e0 !== 1) begin n_fail++;
         $display("FAIL busy_ignore: got dones=%0d enables=%0d want 1 1",
                  done_cnt - d0, ena_cnt - e0); end
      n_vec++; if (last_addr !== 11'd4 || rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL busy_data: got addr=%0d rd=%h want 4 deadbeef",
                  last_addr, rdata); end
   endtask

   task automatic test_back_to_back();
      int d0;
      @(negedge clk);
      d0 = done_cnt;
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h024;
      repeat (9) @(posedge clk);
      #1 req = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++; if (done_cnt - d0 !== 3) begin n_fail++;
         $display("FAIL back_to_back: got %0d dones want 3", done_cnt - d0); end
      n_vec++; if (rdata !== 32'h80013344) begin n_fail++;
         $display("FAIL b2b_data: got %h want 80013344", rdata); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_reset_mid();
      test_busy();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
